// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter for NREQ producers sharing one FIFO write port.
// Define ARB_BURST_EN to let an owner keep the grant for up to BURST_LEN consecutive accepts.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        data,
  input  logic                      full,
  output logic [NREQ-1:0]           gnt,
  output logic                      wr_en,
  output logic [DW-1:0]             d_in,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] last_q, last_d, rr_idx, win;
  logic          rr_hit, hit, acc;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NREQ);
  endfunction

  // Descending scan so the last hit written is the nearest index after last_q.
  always_comb begin
    rr_idx = last_q;
    rr_hit = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (req[wrap(int'(last_q) + k)]) begin
        rr_hit = 1'b1;
        rr_idx = wrap(int'(last_q) + k);
      end
  end

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          keep;

  assign keep = (state_q == BURST) && req[last_q];
  assign win  = keep ? last_q : rr_idx;
  assign hit  = keep | rr_hit;
  assign busy = state_q == BURST;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  // A round-robin accept (from IDLE or after the owner dropped) opens a fresh burst.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (acc && keep) begin
      state_d = (cnt_q == CW'(BURST_LEN - 1)) ? IDLE : BURST;
      cnt_d   = (cnt_q == CW'(BURST_LEN - 1)) ? '0 : cnt_q + CW'(1);
    end else if (acc) begin
      state_d = (BURST_LEN > 1) ? BURST : IDLE;
      cnt_d   = (BURST_LEN > 1) ? CW'(1) : '0;
    end else if (state_q == BURST && !req[last_q] && !full) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
`else
  assign win  = rr_idx;
  assign hit  = rr_hit;
  assign busy = 1'b0;
`endif

  always_comb begin
    acc    = hit && !full && rst;
    gnt    = acc ? (NREQ'(1) << win) : '0;
    wr_en  = acc;
    d_in   = acc ? data[win*DW +: DW] : '0;
    last_d = acc ? win : last_q;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= IW'(NREQ - 1);
    else      last_q <= last_d;

  assign owner = last_q;
endmodule
